alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle unsigned multiplier controller for the ALU. It time-shares a single WIDTH+1-bit ripple adder, the existing `nbit_full_adder`, to compute a full-width product by shift-and-add over WIDTH+1 iterations. It sits between the instruction decode/issue stage and the ALU result mux, and uses a valid/ready handshake on both the operand and result sides.

## Interface
- WIDTH, 3, MSB index of each operand; operands are WIDTH+1 bits and the product is 2*WIDTH+2 bits.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operands presented.
- op_ready  out  1  block can accept operands; high only in IDLE.
- a_in  in  WIDTH+1  multiplicand, unsigned.
- b_in  in  WIDTH+1  multiplier, unsigned.
- res_valid  out  1  product available; high only in DONE.
- res_ready  in  1  consumer takes the product.
- product  out  2*WIDTH+2  {acc, mq}; valid while res_valid is high.
- busy  out  1  high in RUN or DONE.

## Operation
- Registers:
  - M: multiplicand, WIDTH+1 bits.
  - acc: accumulator, WIDTH+1 bits.
  - mq: multiplier/quotient shift register, WIDTH+1 bits.
  - cnt: iteration counter, $clog2(WIDTH+2) bits.
  - state.
- States: IDLE, RUN, DONE.
- IDLE: op_ready=1. On op_valid&&op_ready:
  - load M=a_in, mq=b_in, acc=0, cnt=0.
  - go to RUN.
- RUN, one iteration per cycle:
  - adder inputs: a=acc, b = mq[0] ? M : 0, ci=0; outputs sum and co.
  - acc ← {co, sum[WIDTH:1]}; mq ← {sum[0], mq[WIDTH:1]}; cnt ← cnt+1.
  - when cnt == WIDTH (last iteration), go to DONE.
  - op_valid is ignored.
- DONE: res_valid=1 and product={acc, mq} is held stable. On res_ready, go to IDLE.
- No carry-out or overflow is possible. The product is exact; maximum (2^(WIDTH+1)-1)^2 fits in 2*WIDTH+2 bits.
- op_valid and res_ready high together while in DONE: the result drains and the state goes to IDLE. The new operand is not accepted that cycle because op_ready=0; it is accepted on the following cycle.
- Reset, asynchronous and at any time, including mid-RUN or DONE:
  - state=IDLE; acc, mq, M, cnt = 0.
  - the in-flight operation is discarded with no partial result.
- Outputs during and after reset: op_ready=1, res_valid=0, busy=0, product=0.

## Timing
- Accept at edge E0 → RUN. Iterations occur at edges E1..E(WIDTH+1). DONE is entered at E(WIDTH+1).
- res_valid rises WIDTH+1 cycles after the accept edge: 4 cycles for WIDTH=3.
- Result hold: product and res_valid stay constant for any number of cycles with res_ready=0.
- Throughput: one multiply per WIDTH+3 cycles minimum (accept, WIDTH+1 iterations, drain, re-accept).
- Combinational paths:
  - op_ready, res_valid and busy are decoded from state only.
  - There is no combinational path from op_valid or res_ready to any output.
- Critical path: one WIDTH+1-bit ripple through the adder plus the operand mux.

## Structure
- Shared package `alu_pkg`:
  - `mul_state_t` enum {IDLE, RUN, DONE}.
  - any ALU-wide width constants.
- One sub-module: `nbit_full_adder #(.WIDTH(WIDTH))`, instantiated once.
  - Its operand b comes from the mq[0]-gated M mux.
  - ci is tied to 0.
- The FSM, counter and shift registers are in the top module.

## Test plan
- a=3, b=5, WIDTH=3: accept → res_valid exactly 4 cycles later, product=8'h0F. Check op_ready=0 and busy=1 throughout.
- a=15, b=15 → product=8'hE1 (225). Also a=0, b=9 → 8'h00, and a=9, b=0 → 8'h00.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → product stable, no new accept despite op_valid=1. Release → IDLE next cycle.
- Back-to-back: op_valid held high with res_ready=1 and pairs (2,7) then (11,13) → products 8'h0E then 8'h8F. The second accept occurs the cycle after the drain.
- Reset asserted mid-RUN (after 2 iterations) → outputs immediately op_ready=1, res_valid=0, busy=0, product=0. After release, the next operation (6×6) returns 8'h24 correctly.
- Random sweep of all 256 operand pairs for WIDTH=3, plus 1000 random pairs at WIDTH=7 → product matches a*b.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU-wide width constant and multiplier sequencer state encoding.
package alu_pkg;
    localparam int ALU_WIDTH = 3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/nbit_full_adder.sv
// nbit_full_adder: WIDTH+1-bit ripple-carry adder with carry in and carry out.
module nbit_full_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           ci,
    output logic [WIDTH:0] sum,
    output logic           co
);
    logic [WIDTH+1:0] w_c;
    assign w_c[0] = ci;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    assign co = w_c[WIDTH+1];
endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: unsigned shift-and-add multiplier time-sharing one ripple adder,
// valid/ready handshakes on operand and result sides.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH:0]     a_in,
    input  logic [WIDTH:0]     b_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH+1:0] product,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 2);

    mul_state_t     r_state;
    logic [WIDTH:0] r_m;
    logic [WIDTH:0] r_acc;
    logic [WIDTH:0] r_mq;
    logic [CW-1:0]  r_cnt;
    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;
    logic           w_co;

    assign w_addend = r_mq[0] ? r_m : '0;

    nbit_full_adder #(.WIDTH(WIDTH)) u_add (
        .a   (r_acc),
        .b   (w_addend),
        .ci  (1'b0),
        .sum (w_sum),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (op_valid) begin
                    r_m     <= a_in;
                    r_mq    <= b_in;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                // carry-out re-enters the accumulator MSB, sum LSB shifts into mq
                RUN: begin
                    r_acc <= {w_co, w_sum[WIDTH:1]};
                    r_mq  <= {w_sum[0], r_mq[WIDTH:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH)) r_state <= DONE;
                end
                DONE: if (res_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready  = r_state == IDLE;
    assign res_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign product   = {r_acc, r_mq};
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed and sweep stimulus with a queue-based scoreboard
// for a WIDTH=3 and a WIDTH=7 instance.
module tb_alu_mul_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        op_valid = 0, res_ready = 0;
    logic [3:0]  a_in = 0, b_in = 0;
    logic        op_ready, res_valid, busy;
    logic [7:0]  product;
    logic        op_valid7 = 0, res_ready7 = 1;
    logic [7:0]  a7 = 0, b7 = 0;
    logic        op_ready7, res_valid7, busy7;
    logic [15:0] product7;
    int          checks = 0, errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp7_q[$];

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .a_in(a_in), .b_in(b_in), .res_valid(res_valid), .res_ready(res_ready),
        .product(product), .busy(busy)
    );

    alu_mul_sequencer #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid7), .op_ready(op_ready7),
        .a_in(a7), .b_in(b7), .res_valid(res_valid7), .res_ready(res_ready7),
        .product(product7), .busy(busy7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitors pop the scoreboard whenever a result is handed over
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", {24'd0, product}, 32'hDEAD);
            else check("product", {24'd0, product}, {24'd0, exp_q.pop_front()});
        end
        if (rst_n && res_valid7 && res_ready7) begin
            if (exp7_q.size() == 0) check("unexpected_result7", {16'd0, product7}, 32'hDEAD);
            else check("product7", {16'd0, product7}, {16'd0, exp7_q.pop_front()});
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!op_ready) check("accept_timeout", 0, 1);
        op_valid = 1; a_in = a; b_in = b;
        exp_q.push_back(8'(a) * 8'(b));
        @(posedge clk); #1;
        op_valid = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!res_valid) check("result_timeout", 0, 1);
    endtask

    task automatic drain();
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int n;
        issue(a, b);
        wait_valid(n);
        check("directed", {24'd0, product}, {24'd0, exp});
        drain();
    endtask

    task automatic run7(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!op_ready7 && n < 50) begin @(posedge clk); #1; n++; end
        if (!op_ready7) check("accept_timeout7", 0, 1);
        op_valid7 = 1; a7 = a; b7 = b;
        exp7_q.push_back(16'(a) * 16'(b));
        @(posedge clk); #1;
        op_valid7 = 0;
        n = 0;
        while (!res_valid7 && n < 40) begin @(posedge clk); #1; n++; end
        if (!res_valid7) check("result_timeout7", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        @(posedge clk); @(negedge clk);
        check("rst_op_ready", {31'd0, op_ready}, 1);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_product", {24'd0, product}, 0);
        @(posedge clk); #1; rst_n = 1;

        issue(3, 5);
        n = 0;
        while (!res_valid && n < 40) begin
            check("run_op_ready", {31'd0, op_ready}, 0);
            check("run_busy", {31'd0, busy}, 1);
            @(posedge clk); #1; n++;
        end
        check("latency", n, 4);
        check("3x5", {24'd0, product}, 32'h0F);
        drain();

        run_one(15, 15, 8'hE1);
        run_one(0, 9, 8'h00);
        run_one(9, 0, 8'h00);

        issue(4, 7);
        wait_valid(n);
        op_valid = 1; a_in = 1; b_in = 1;
        repeat (10) begin
            @(posedge clk); #1;
            check("hold_product", {24'd0, product}, 32'h1C);
            check("hold_valid", {31'd0, res_valid}, 1);
            check("hold_no_accept", {31'd0, op_ready}, 0);
        end
        op_valid = 0;
        drain();
        check("release_idle", {31'd0, op_ready}, 1);
        check("release_valid", {31'd0, res_valid}, 0);

        res_ready = 1;
        op_valid = 1; a_in = 2; b_in = 7;
        exp_q.push_back(8'h0E);
        @(posedge clk); #1;
        a_in = 11; b_in = 13;
        exp_q.push_back(8'h8F);
        n = 0;
        while (!op_ready && n < 40) begin @(posedge clk); #1; n++; end
        check("b2b_drain_cycle", n, 5);
        @(posedge clk); #1;
        check("b2b_second_accept", {31'd0, busy}, 1);
        op_valid = 0;
        wait_valid(n);
        check("b2b_second", {24'd0, product}, 32'h8F);
        @(posedge clk); #1;
        res_ready = 0;

        issue(5, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0; #1;
        check("midrst_op_ready", {31'd0, op_ready}, 1);
        check("midrst_res_valid", {31'd0, res_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_product", {24'd0, product}, 0);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1;
        run_one(6, 6, 8'h24);

        res_ready = 1;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                issue(4'(i), 4'(j));
                wait_valid(n);
                @(posedge clk); #1;
            end
        res_ready = 0;

        run7(8'hFF, 8'hFF);
        check("w7_max", {16'd0, product7}, 32'hFE01);
        for (int k = 0; k < 1000; k++) run7(8'($urandom), 8'($urandom));

        check("queue_empty", exp_q.size(), 0);
        check("queue7_empty", exp7_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
